// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared types and next-state
// function for the time-shared sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    A = 2'b00,
    B = 2'b01,
    C = 2'b10
  } st_e;

  // Two-in-a-row detector step; code 2'b11 acts as A.
  function automatic logic [1:0] next_st(
    input logic [1:0] s,
    input logic       w
  );
    logic [1:0] r;
    r = A;
    if (w) begin
      unique case (1'b1)
        (s == B),
        (s == C): r = C;
        default:  r = B;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_sched_arb.sv
// rr_arbiter: round-robin grant scanning from ptr,
// plus granted index and updated pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any,
  output logic [PW-1:0] ptr_nxt
);

  int j;

  // First requester at or after ptr, cyclically.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any     = 1'b0;
    ptr_nxt = ptr;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        idx     = PW'(j);
        ptr_nxt = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: N channels sharing one
// next-state datapath under round-robin grant.
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] w,
  input  logic [N-1:0] clr,
  output logic [N-1:0] gnt,
  output logic [N-1:0] z,
  output logic [N-1:0] hit
);

  localparam int PW = $clog2(N);

  logic [N-1:0][1:0] st;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [PW-1:0]     gidx;
  logic [N-1:0]      gnt_a;
  logic              any;
  logic [1:0]        ns;
  logic [N-1:0]      hit_d;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt_a),
    .idx     (gidx),
    .any     (any),
    .ptr_nxt (ptr_nxt)
  );

  assign gnt = Reset ? '0 : gnt_a;
  assign ns  = next_st(st[gidx], w[gidx]);

  // B->C transition on the granted, uncleared channel.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < N; i++) begin
      hit_d[i] = gnt_a[i] && !clr[i] &&
                 (st[i] == B) && (ns == C);
    end
  end

  // Moore output from the state register only.
  always_comb begin
    z = '0;
    for (int i = 0; i < N; i++) begin
      z[i] = (st[i] == C);
    end
  end

  // Per-channel state; clear beats a grant.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      st <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr[i])        st[i] <= A;
        else if (gnt_a[i]) st[i] <= ns;
      end
    end
  end

  // Pointer advances only when something is granted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)    ptr <= '0;
    else if (any) ptr <= ptr_nxt;
  end

  // One-cycle hit pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) hit <= '0;
    else       hit <= hit_d;
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: directed self-checking bench
// for the time-shared sequence detector.
module tb_seq_detect_sched;

  logic       Clock;
  logic       Reset;
  logic [3:0] req;
  logic [3:0] w;
  logic [3:0] clr;
  logic [3:0] gnt;
  logic [3:0] z;
  logic [3:0] hit;

  int tests;
  int fails;

  seq_detect_sched #(.N(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .req   (req),
    .w     (w),
    .clr   (clr),
    .gnt   (gnt),
    .z     (z),
    .hit   (hit)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    w     = '0;
    clr   = '0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    req   = 4'b1111;
    w     = 4'b1111;
    clr   = '0;
    @(negedge Clock);
    #1;
    tests++;
    if (gnt !== 4'b0000) begin
      fails++;
      $display("FAIL reset_gnt got %b want 0000", gnt);
    end
    tests++;
    if (z !== 4'b0000 || hit !== 4'b0000) begin
      fails++;
      $display("FAIL reset_out z %b hit %b want 0000", z, hit);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [3:0] ez [3];
    logic [3:0] eh [3];
    ez = '{4'b0000, 4'b0001, 4'b0001};
    eh = '{4'b0000, 4'b0001, 4'b0000};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req = 4'b0001;
      w   = 4'b0001;
      #1;
      tests++;
      if (gnt !== 4'b0001) begin
        fails++;
        $display("FAIL single_gnt c%0d got %b want 0001", c, gnt);
      end
      @(negedge Clock);
      tests++;
      if (z !== ez[c] || hit !== eh[c]) begin
        fails++;
        $display("FAIL single_out c%0d z %b hit %b want %b %b",
                 c, z, hit, ez[c], eh[c]);
      end
    end
    req = '0;
    w   = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [8];
    logic [3:0] ez [8];
    logic [3:0] eh [8];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
           4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ez = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
           4'b0001, 4'b0011, 4'b0111, 4'b1111};
    eh = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
           4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req = 4'b1111;
      w   = 4'b1111;
      #1;
      tests++;
      if (gnt !== eg[c]) begin
        fails++;
        $display("FAIL rr_gnt c%0d got %b want %b", c, gnt, eg[c]);
      end
      @(negedge Clock);
      tests++;
      if (z !== ez[c] || hit !== eh[c]) begin
        fails++;
        $display("FAIL rr_out c%0d z %b hit %b want %b %b",
                 c, z, hit, ez[c], eh[c]);
      end
    end
    req = '0;
    w   = '0;
  endtask

  // Follows test_round_robin: all in C, ptr = 0.
  task automatic test_drop_to_a();
    req = 4'b0100;
    w   = 4'b0000;
    #1;
    tests++;
    if (gnt !== 4'b0100) begin
      fails++;
      $display("FAIL drop_gnt got %b want 0100", gnt);
    end
    @(negedge Clock);
    tests++;
    if (z !== 4'b1011) begin
      fails++;
      $display("FAIL drop_z got %b want 1011", z);
    end
    w = 4'b0100;
    #1;
    tests++;
    if (gnt !== 4'b0100) begin
      fails++;
      $display("FAIL drop_gnt2 got %b want 0100", gnt);
    end
    @(negedge Clock);
    tests++;
    if (z !== 4'b1011 || hit !== 4'b0000) begin
      fails++;
      $display("FAIL drop_b z %b hit %b want 1011 0000", z, hit);
    end
    req = '0;
    w   = '0;
  endtask

  task automatic test_clear();
    do_reset();
    req = 4'b0010;
    w   = 4'b0010;
    @(negedge Clock);
    clr = 4'b0010;
    #1;
    tests++;
    if (gnt !== 4'b0010) begin
      fails++;
      $display("FAIL clr_gnt got %b want 0010", gnt);
    end
    @(negedge Clock);
    clr = '0;
    tests++;
    if (z !== 4'b0000 || hit !== 4'b0000) begin
      fails++;
      $display("FAIL clr_out z %b hit %b want 0000 0000", z, hit);
    end
    tests++;
    if (dut.st[1] !== 2'b00) begin
      fails++;
      $display("FAIL clr_st got %b want 00", dut.st[1]);
    end
    @(negedge Clock);
    tests++;
    if (z !== 4'b0000) begin
      fails++;
      $display("FAIL clr_then_b z got %b want 0000", z);
    end
    @(negedge Clock);
    tests++;
    if (z !== 4'b0010 || hit !== 4'b0010) begin
      fails++;
      $display("FAIL clr_then_c z %b hit %b want 0010 0010", z, hit);
    end
    req = '0;
    w   = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1111;
    w   = 4'b1111;
    repeat (8) @(negedge Clock);
    req = 4'b0011;
    repeat (2) @(negedge Clock);
    req = 4'b1111;
    #1;
    tests++;
    if (gnt !== 4'b0100 || z !== 4'b1111) begin
      fails++;
      $display("FAIL pre_rst gnt %b z %b want 0100 1111", gnt, z);
    end
    #2;
    Reset = 1'b1;
    #1;
    tests++;
    if (z !== 4'b0000 || hit !== 4'b0000 || gnt !== 4'b0000) begin
      fails++;
      $display("FAIL async_rst z %b hit %b gnt %b want 0",
               z, hit, gnt);
    end
    @(negedge Clock);
    Reset = 1'b0;
    req   = 4'b1100;
    w     = 4'b0000;
    #1;
    tests++;
    if (gnt !== 4'b0100) begin
      fails++;
      $display("FAIL post_rst_gnt got %b want 0100", gnt);
    end
    @(negedge Clock);
    req = '0;
  endtask

  task automatic test_illegal();
    do_reset();
    force dut.st = 8'b11_00_00_00;
    req = 4'b1000;
    w   = 4'b1000;
    #1;
    release dut.st;
    #1;
    tests++;
    if (gnt !== 4'b1000 || z !== 4'b0000) begin
      fails++;
      $display("FAIL ill_pre gnt %b z %b want 1000 0000", gnt, z);
    end
    @(negedge Clock);
    tests++;
    if (dut.st[3] !== 2'b01 || z !== 4'b0000) begin
      fails++;
      $display("FAIL ill_next st %b z %b want 01 0000",
               dut.st[3], z);
    end
    @(negedge Clock);
    tests++;
    if (z !== 4'b1000 || hit !== 4'b1000) begin
      fails++;
      $display("FAIL ill_c z %b hit %b want 1000 1000", z, hit);
    end
    req = '0;
    w   = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    req   = '0;
    w     = '0;
    clr   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop_to_a();
    test_clear();
    test_async_reset();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
